ptp_int_master: RTL and testbench
=================================

# ptp_int_master

Bus-initiator side of the PTP interrupt path. It watches the combined PTP interrupt line and reads the interrupt status register at `INT_BASE_ADDR`, relying on that register's clear-on-read behaviour. It then issues one-cycle service pulses per enabled source (xms, rx_ptp, tx_ptp) and performs interrupt-mask writes to `INT_BASE_ADDR+1`. It drives the 32-bit on-chip bus toward the interrupt controller and replaces software polling in firmware-less builds.

## Interface
Parameters:
- `INT_BASE_ADDR`, 32'h300: status register address; mask register is at `+1`.
- `INIT_MASK`, 3'b111: mask value written once after reset.
- `RD_LEN`, 2: cycles `bus2ip_rd_ce_o` is held per read, range 1..4.
- `GAP_LEN`, 4: idle cycles after a read, address held; minimum 4.

Ports:
- `bus2ip_clk` in 1: sole clock.
- `bus2ip_rst` in 1: reset, asynchronous, active-high.
- `int_ptp_i` in 1: combined interrupt, level, synchronous to `bus2ip_clk`.
- `ip2bus_data_i` in 32: read data, valid while `rd_ce` is high.
- `bus2ip_addr_o` out 32: bus address.
- `bus2ip_data_o` out 32: write data.
- `bus2ip_rd_ce_o` out 1: read enable.
- `bus2ip_wr_ce_o` out 1: write enable.
- `mask_wr_i` in 1: request a mask update (pulse).
- `mask_i` in 3: new mask, sampled with `mask_wr_i`.
- `evt_xms_o`, `evt_rx_o`, `evt_tx_o` out 1 each: one-cycle service pulses for status bits [2], [1], [0].
- `status_o` out 3: raw status from the last read.
- `mask_o` out 3: shadow copy of the mask last written.
- `spur_cnt_o` out 8: saturating count of reads returning 0.
- `busy_o` out 1: high whenever state ≠ IDLE.

## Operation
- FSM states: INIT, IDLE, RD, GAP, DISP, MWR.
- INIT (first cycle after reset release):
  - `wr_ce`=1, `addr`=BASE+1, `data`={29'b0, INIT_MASK}.
  - `mask_o`←INIT_MASK; go to IDLE.
- IDLE, priority order:
  - Pending mask write → MWR.
  - Else `int_ptp_i`=1 → RD.
  - Else stay.
- MWR (one cycle): `wr_ce`=1, `addr`=BASE+1, `data`={29'b0, pend_mask}; `mask_o`←pend_mask; clear pending; go to IDLE.
- Mask requests: `mask_wr_i` in any state latches `mask_i` into pend_mask and sets pending. The last request wins. A request coincident with the MWR cycle re-sets pending.
- RD (`RD_LEN` cycles): `rd_ce`=1, `addr`=BASE. On the final RD cycle, `ip2bus_data_i[2:0]` is captured into `status_o`.
- GAP (`GAP_LEN` cycles): `rd_ce`=0, `wr_ce`=0, `addr` held at BASE. This lets the controller's read-clear (two cycles after `rd_ce` falls) and its registered interrupt output settle.
- DISP (one cycle):
  - `evt_*` = `status_o & mask_o`. Status bits set while masked are cleared by the read and are not reported.
  - If `status_o`==0, `spur_cnt_o` increments, saturating at 255.
  - Go to IDLE.
- A source re-firing after the clear keeps `int_ptp_i` high, so IDLE re-enters RD. No event is lost.
- `rd_ce` and `wr_ce` are never high together. They are never high for two consecutive transactions without passing through IDLE.
- Outside INIT/MWR/RD/GAP: `addr`=0, `data`=0.

## Timing
- Reset values:
  - All outputs 0; `mask_o`=0, `spur_cnt_o`=0; pending=0; state=INIT.
  - Asserting reset mid-transaction drops `rd_ce`/`wr_ce` immediately (asynchronous).
- All outputs are registered.
- Service sequence (defaults), with `int_ptp_i` sampled high in IDLE at cycle 0:
  - Cycles 1-2: RD, capture at the end of cycle 2.
  - Cycles 3-6: GAP.
  - Cycle 7: DISP (`evt_*` pulse).
  - Cycle 8: IDLE.
- Interrupt-to-event latency: 7 cycles. Minimum re-service period: 8 cycles.
- Mask write: `wr_ce` visible the cycle after IDLE sees pending; `mask_o` updates the same cycle.
- A mask write requested during RD/GAP executes after DISP. DISP uses the old `mask_o`.

## Structure
- Shared package holds:
  - FSM state enum.
  - Bit positions XMS=2, RX=1, TX=0.
  - Register offsets STATUS=0, MASK=1.
- One sub-module is natural: `ptp_int_bus_seq`, the RD/GAP/MWR bus-cycle sequencer with its length counter. The top holds the FSM, the pending mask and the counters.

## Test plan
- Reset release: one INIT write, addr 0x301, data 0x7 → `mask_o`=3'b111, then idle; bus quiet while `int_ptp_i`=0.
- Interrupt with slave status 3'b010 → `rd_ce` high cycles 1-2 at 0x300, `evt_rx_o` pulse at cycle 7, `status_o`=3'b010, other events 0.
- `mask_wr_i` with `mask_i`=3'b001, then status 3'b101 → single `evt_tx_o` pulse; `evt_xms_o` stays 0.
- `mask_wr_i` during GAP → MWR write to 0x301 starts the cycle after DISP→IDLE; DISP uses the old mask.
- Status read returns 0 three times → `spur_cnt_o`=3. Force 300 spurious reads → `spur_cnt_o`=255.
- Reset asserted mid-RD → `rd_ce`=0 immediately; after release, the INIT write is repeated.

Source files
------------

// File: rtl/ptp_int_master_pkg.sv
// Shared definitions for the PTP interrupt-master slice: FSM states,
// status bit positions, register offsets and small helpers.
package ptp_int_master_pkg;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_RD   = 3'd2,
    ST_GAP  = 3'd3,
    ST_DISP = 3'd4,
    ST_MWR  = 3'd5
  } state_t;

  // Status / mask bit positions
  localparam int unsigned XMS_BIT = 2;
  localparam int unsigned RX_BIT  = 1;
  localparam int unsigned TX_BIT  = 0;

  // Register offsets from the interrupt block base address
  localparam logic [31:0] REG_STATUS = 32'd0;
  localparam logic [31:0] REG_MASK   = 32'd1;

  // Saturating 8-bit increment
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ptp_int_bus_seq.sv
// Bus-cycle sequencer: drives rd_ce/wr_ce/addr/data for the RD, GAP and
// mask-write phases and times the RD/GAP phase lengths for the top FSM.
module ptp_int_bus_seq
  import ptp_int_master_pkg::*;
#(
  parameter logic [31:0] INT_BASE_ADDR = 32'h300,
  parameter int unsigned RD_LEN        = 2,
  parameter int unsigned GAP_LEN       = 4
) (
  input  logic        bus2ip_clk,
  input  logic        bus2ip_rst,
  input  state_t      state,
  input  state_t      state_nxt,
  input  logic [2:0]  wr_mask,
  output logic        rd_last,
  output logic        gap_last,
  output logic        rd_ce,
  output logic        wr_ce,
  output logic [31:0] addr,
  output logic [31:0] data
);

  localparam logic [7:0] RD_LAST  = 8'(RD_LEN - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_LEN - 1);

  logic [7:0] cnt;
  logic       wr_go;
  logic       rd_phase_nxt;

  // INIT writes on its way out to IDLE, so it is keyed off the current state
  assign wr_go        = (state_nxt == ST_MWR) || (state == ST_INIT);
  assign rd_phase_nxt = (state_nxt == ST_RD) || (state_nxt == ST_GAP);
  assign rd_last      = (state == ST_RD)  && (cnt == RD_LAST);
  assign gap_last     = (state == ST_GAP) && (cnt == GAP_LAST);

  // Phase length counter, restarted on every state change
  always_ff @(posedge bus2ip_clk or posedge bus2ip_rst) begin
    if (bus2ip_rst) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else if (state == ST_RD || state == ST_GAP) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Registered bus outputs reflecting the phase about to be entered
  always_ff @(posedge bus2ip_clk or posedge bus2ip_rst) begin
    if (bus2ip_rst) begin
      rd_ce <= 1'b0;
      wr_ce <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else begin
      rd_ce <= (state_nxt == ST_RD);
      wr_ce <= wr_go;
      if (rd_phase_nxt) begin
        addr <= INT_BASE_ADDR + REG_STATUS;
      end else if (wr_go) begin
        addr <= INT_BASE_ADDR + REG_MASK;
      end else begin
        addr <= '0;
      end
      data <= wr_go ? {29'b0, wr_mask} : '0;
    end
  end

endmodule

// File: rtl/ptp_int_master.sv
// PTP interrupt bus master: reads the clear-on-read status register when the
// combined interrupt is high, pulses one event per enabled source, and keeps
// the controller's mask register in step with requested mask updates.
module ptp_int_master
  import ptp_int_master_pkg::*;
#(
  parameter logic [31:0] INT_BASE_ADDR = 32'h300,
  parameter logic [2:0]  INIT_MASK     = 3'b111,
  parameter int unsigned RD_LEN        = 2,
  parameter int unsigned GAP_LEN       = 4
) (
  input  logic        bus2ip_clk,
  input  logic        bus2ip_rst,
  input  logic        int_ptp_i,
  input  logic [31:0] ip2bus_data_i,
  output logic [31:0] bus2ip_addr_o,
  output logic [31:0] bus2ip_data_o,
  output logic        bus2ip_rd_ce_o,
  output logic        bus2ip_wr_ce_o,
  input  logic        mask_wr_i,
  input  logic [2:0]  mask_i,
  output logic        evt_xms_o,
  output logic        evt_rx_o,
  output logic        evt_tx_o,
  output logic [2:0]  status_o,
  output logic [2:0]  mask_o,
  output logic [7:0]  spur_cnt_o,
  output logic        busy_o
);

  state_t     state;
  state_t     state_nxt;
  logic       pend;
  logic [2:0] pend_mask;
  logic       rd_last;
  logic       gap_last;
  logic       mwr_go;
  logic       disp_go;
  logic [2:0] hit;
  logic [2:0] wr_mask;
  logic       unused_rd_hi;

  assign unused_rd_hi = ^ip2bus_data_i[31:3];
  assign mwr_go       = (state == ST_IDLE) && pend;
  assign disp_go      = (state_nxt == ST_DISP);
  assign hit          = status_o & mask_o;
  assign wr_mask      = (state == ST_INIT) ? INIT_MASK : pend_mask;

  // Next-state selection; a pending mask write outranks an interrupt
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_INIT: state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (pend) begin
          state_nxt = ST_MWR;
        end else if (int_ptp_i) begin
          state_nxt = ST_RD;
        end
      end
      ST_RD:   if (rd_last)  state_nxt = ST_GAP;
      ST_GAP:  if (gap_last) state_nxt = ST_DISP;
      ST_DISP: state_nxt = ST_IDLE;
      ST_MWR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_INIT;
    endcase
  end

  // State register
  always_ff @(posedge bus2ip_clk or posedge bus2ip_rst) begin
    if (bus2ip_rst) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Pending mask request; a new request wins over the clear so none is lost
  always_ff @(posedge bus2ip_clk or posedge bus2ip_rst) begin
    if (bus2ip_rst) begin
      pend      <= 1'b0;
      pend_mask <= '0;
    end else if (mask_wr_i) begin
      pend      <= 1'b1;
      pend_mask <= mask_i;
    end else if (mwr_go) begin
      pend      <= 1'b0;
    end
  end

  // Shadow mask, captured status and busy flag
  always_ff @(posedge bus2ip_clk or posedge bus2ip_rst) begin
    if (bus2ip_rst) begin
      mask_o   <= '0;
      status_o <= '0;
      busy_o   <= 1'b0;
    end else begin
      if (state == ST_INIT) begin
        mask_o <= INIT_MASK;
      end else if (mwr_go) begin
        mask_o <= pend_mask;
      end
      if (rd_last) begin
        status_o <= ip2bus_data_i[2:0];
      end
      busy_o <= (state_nxt != ST_IDLE);
    end
  end

  // Service pulses and spurious-read counter, registered into the DISP cycle
  always_ff @(posedge bus2ip_clk or posedge bus2ip_rst) begin
    if (bus2ip_rst) begin
      evt_xms_o  <= 1'b0;
      evt_rx_o   <= 1'b0;
      evt_tx_o   <= 1'b0;
      spur_cnt_o <= '0;
    end else begin
      evt_xms_o <= disp_go && hit[XMS_BIT];
      evt_rx_o  <= disp_go && hit[RX_BIT];
      evt_tx_o  <= disp_go && hit[TX_BIT];
      if (disp_go && (status_o == 3'b000)) begin
        spur_cnt_o <= sat_inc8(spur_cnt_o);
      end
    end
  end

  ptp_int_bus_seq #(
    .INT_BASE_ADDR (INT_BASE_ADDR),
    .RD_LEN        (RD_LEN),
    .GAP_LEN       (GAP_LEN)
  ) u_bus_seq (
    .bus2ip_clk (bus2ip_clk),
    .bus2ip_rst (bus2ip_rst),
    .state      (state),
    .state_nxt  (state_nxt),
    .wr_mask    (wr_mask),
    .rd_last    (rd_last),
    .gap_last   (gap_last),
    .rd_ce      (bus2ip_rd_ce_o),
    .wr_ce      (bus2ip_wr_ce_o),
    .addr       (bus2ip_addr_o),
    .data       (bus2ip_data_o)
  );

endmodule

// File: tb/tb_ptp_int_master.sv
// Randomized bench for ptp_int_master: a transaction-level model schedules the
// expected per-cycle bus activity for each service / mask write and compares.
module tb_ptp_int_master;

  localparam logic [31:0] BASE   = 32'h300;
  localparam logic [2:0]  INIT_M = 3'b111;
  localparam int          RDL    = 2;
  localparam int          GAPL   = 4;

  logic        clk;
  logic        rst;
  logic        int_ptp;
  logic [31:0] rd_data;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rd_ce;
  logic        wr_ce;
  logic        mask_wr;
  logic [2:0]  mask_in;
  logic        evt_xms;
  logic        evt_rx;
  logic        evt_tx;
  logic [2:0]  status;
  logic [2:0]  mask;
  logic [7:0]  spur;
  logic        busy;

  ptp_int_master #(
    .INT_BASE_ADDR (BASE),
    .INIT_MASK     (INIT_M),
    .RD_LEN        (RDL),
    .GAP_LEN       (GAPL)
  ) dut (
    .bus2ip_clk     (clk),
    .bus2ip_rst     (rst),
    .int_ptp_i      (int_ptp),
    .ip2bus_data_i  (rd_data),
    .bus2ip_addr_o  (addr),
    .bus2ip_data_o  (wdata),
    .bus2ip_rd_ce_o (rd_ce),
    .bus2ip_wr_ce_o (wr_ce),
    .mask_wr_i      (mask_wr),
    .mask_i         (mask_in),
    .evt_xms_o      (evt_xms),
    .evt_rx_o       (evt_rx),
    .evt_tx_o       (evt_tx),
    .status_o       (status),
    .mask_o         (mask),
    .spur_cnt_o     (spur),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks;
  int unsigned n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One expected cycle of DUT behaviour
  typedef struct {
    logic        idle;
    logic        busy;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  evt;
    logic        s_upd;
    logic [2:0]  s_val;
    logic        m_upd;
    logic [2:0]  m_val;
    logic        spur_inc;
    logic [2:0]  rdst;
  } ent_t;

  ent_t q[$];
  ent_t cur;

  logic [2:0] m_status;
  logic [2:0] m_mask;
  logic [2:0] m_pend_mask;
  logic [7:0] m_spur;
  logic       m_pend;

  int unsigned p_int;
  int unsigned p_mask;
  logic        zero_status;

  function automatic ent_t blank();
    ent_t e;
    e = '{default: '0};
    return e;
  endfunction

  function automatic ent_t idle_ent();
    ent_t e;
    e = blank();
    e.idle = 1'b1;
    return e;
  endfunction

  task automatic model_reset();
    ent_t e;
    q.delete();
    m_status    = '0;
    m_mask      = '0;
    m_pend_mask = '0;
    m_spur      = '0;
    m_pend      = 1'b0;
    // the reset-time mask write lands in the first IDLE cycle
    e        = idle_ent();
    e.wr     = 1'b1;
    e.addr   = BASE + 32'd1;
    e.data   = {29'b0, INIT_M};
    e.m_upd  = 1'b1;
    e.m_val  = INIT_M;
    q.push_back(e);
  endtask

  // Transaction decided in an IDLE cycle: schedule all its following cycles
  task automatic decide(input logic int_v);
    ent_t e;
    logic [2:0] st;
    if (m_pend) begin
      e       = blank();
      e.busy  = 1'b1;
      e.wr    = 1'b1;
      e.addr  = BASE + 32'd1;
      e.data  = {29'b0, m_pend_mask};
      e.m_upd = 1'b1;
      e.m_val = m_pend_mask;
      q.push_back(e);
      m_pend  = 1'b0;
    end else if (int_v) begin
      st = zero_status ? 3'b000 : 3'($urandom_range(0, 7));
      for (int i = 0; i < RDL; i++) begin
        e      = blank();
        e.busy = 1'b1;
        e.rd   = 1'b1;
        e.addr = BASE;
        e.rdst = st;
        q.push_back(e);
      end
      for (int i = 0; i < GAPL; i++) begin
        e      = blank();
        e.busy = 1'b1;
        e.addr = BASE;
        if (i == 0) begin
          e.s_upd = 1'b1;
          e.s_val = st;
        end
        q.push_back(e);
      end
      e          = blank();
      e.busy     = 1'b1;
      e.evt      = st & m_mask;
      e.spur_inc = (st == 3'b000);
      q.push_back(e);
    end
  endtask

  // Advance one cycle: check this cycle's outputs, then drive its inputs
  task automatic step();
    logic        int_v;
    logic        mw;
    logic [2:0]  mv;
    logic [31:0] r;
    @(posedge clk);
    #1;
    cur = (q.size() > 0) ? q.pop_front() : idle_ent();
    if (cur.s_upd) m_status = cur.s_val;
    if (cur.m_upd) m_mask = cur.m_val;
    if (cur.spur_inc && m_spur != 8'hFF) m_spur = m_spur + 8'd1;

    check("rd_ce",  {31'b0, rd_ce}, {31'b0, cur.rd});
    check("wr_ce",  {31'b0, wr_ce}, {31'b0, cur.wr});
    check("addr",   addr, cur.addr);
    check("wdata",  wdata, cur.data);
    check("evt",    {29'b0, evt_xms, evt_rx, evt_tx}, {29'b0, cur.evt});
    check("status", {29'b0, status}, {29'b0, m_status});
    check("mask",   {29'b0, mask}, {29'b0, m_mask});
    check("spur",   {24'b0, spur}, {24'b0, m_spur});
    check("busy",   {31'b0, busy}, {31'b0, cur.busy});

    int_v = ($urandom_range(0, 99) < p_int);
    mw    = ($urandom_range(0, 99) < p_mask);
    mv    = 3'($urandom_range(0, 7));
    r     = $urandom();
    if (cur.idle) decide(int_v);
    if (mw) begin
      m_pend      = 1'b1;
      m_pend_mask = mv;
    end

    int_ptp = int_v;
    mask_wr = mw;
    mask_in = mv;
    rd_data = cur.rd ? {r[31:3], cur.rdst} : r;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_ce"}, {31'b0, rd_ce}, 32'd0);
    check({tag, "_wr_ce"}, {31'b0, wr_ce}, 32'd0);
    check({tag, "_addr"},  addr, 32'd0);
    check({tag, "_mask"},  {29'b0, mask}, 32'd0);
    check({tag, "_spur"},  {24'b0, spur}, 32'd0);
    check({tag, "_stat"},  {29'b0, status}, 32'd0);
    check({tag, "_busy"},  {31'b0, busy}, 32'd0);
  endtask

  task automatic release_reset();
    int_ptp = 1'b0;
    mask_wr = 1'b0;
    mask_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic seen;
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    int_ptp     = 1'b0;
    mask_wr     = 1'b0;
    mask_in     = '0;
    rd_data     = '0;
    zero_status = 1'b0;
    p_int       = 0;
    p_mask      = 0;
    cur         = idle_ent();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    release_reset();

    // quiet bus after the reset-time mask write
    run(12);

    // mixed interrupts and mask updates
    p_int  = 30;
    p_mask = 8;
    run(800);

    // back-to-back spurious reads to saturate the counter
    p_int       = 100;
    p_mask      = 0;
    zero_status = 1'b1;
    run(2500);
    check("spur_sat", {24'b0, spur}, 32'd255);
    zero_status = 1'b0;

    p_int  = 40;
    p_mask = 10;
    run(600);

    // reset in the middle of a read
    p_int  = 100;
    p_mask = 0;
    seen   = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (rd_ce) seen = 1'b1;
    end
    check("rd_reached", {31'b0, seen}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrd");
    release_reset();

    p_int  = 35;
    p_mask = 8;
    run(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
